counter_sequencer: RTL and testbench
====================================

# counter_sequencer

- Sequencing controller for the 4-bit binary counter shown on the board LEDs.
- Generates the step tick from the system clock and debounces the two on-board push-buttons (pause/resume and direction).
- Runs a small state machine that drives the 4-bit `count` value consumed by the LED display stage.
- Sits between the top-level pins and the LED display logic; the display stage only ever sees `count`.

## Interface
Parameters:
- `CLK_FREQ`, 27_000_000, system clock frequency in Hz.
- `TICK_HZ`, 2, count steps per second. `TICK_DIV = CLK_FREQ/TICK_HZ` must be ≥ 2.
- `DEBOUNCE_CYCLES`, 270_000, consecutive stable samples needed to accept a new button level (10 ms). Must be ≥ 1.

Ports:
- `sys_clk`  in  1  system clock. The only clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `btn_pause_n`  in  1  pause/resume button, active-low, asynchronous to `sys_clk`.
- `btn_dir_n`  in  1  direction button, active-low, asynchronous to `sys_clk`.
- `count`  out  4  counter value, 0–15.
- `running`  out  1  1 = RUNNING state, 0 = PAUSED state.
- `dir_up`  out  1  1 = count up, 0 = count down.
- `tick`  out  1  one-cycle pulse, high in the cycle after each `count` step.

## Operation
- **Reset values** (while `sys_rst_n` = 0, applied immediately without a clock):
  - `count` = 0, `running` = 1, `dir_up` = 1, `tick` = 0.
  - Prescaler = 0.
  - Synchronizer flops and debounced levels = 1 (released).
  - Debounce counters = 0.
- **Input path, per button:**
  - Two-flop synchronizer.
  - Debounce counter increments on each cycle where the synchronized level ≠ the debounced level, and clears to 0 when they are equal.
  - On the edge where the counter is at `DEBOUNCE_CYCLES-1` and the levels still differ, the debounced level takes the synchronized level and the counter clears.
  - A press event is a 1→0 transition of the debounced level. Releases generate no event.
- **State machine:** states PAUSED and RUNNING; reset state is RUNNING.
  - Pause press event: RUNNING→PAUSED or PAUSED→RUNNING.
  - Direction press event: toggles `dir_up` in either state.
- **Prescaler:**
  - In RUNNING it counts 0..`TICK_DIV-1` and wraps.
  - At the wrap it produces a step: `count` ± 1 modulo 16 (up: 15→0; down: 0→15), and `tick` = 1 in the next cycle.
  - In PAUSED the prescaler is held at 0, `count` is frozen and `tick` = 0.
  - Entering RUNNING restarts the prescaler from 0.
- **Simultaneous events:**
  - Pause event and step in the same cycle: the pause wins and no step occurs.
  - Direction event and step in the same cycle: the step uses the old direction, and the new direction applies from the next step.
  - Pause and direction events in the same cycle: both are applied.
- **Reset mid-operation:** all state returns to the reset values asynchronously. Counting resumes upward from 0 one `TICK_DIV` period after the first clock edge following reset release.

## Timing
- Button to state latency: a stable press first sampled at edge N changes `running`/`dir_up` at edge N + 2 + `DEBOUNCE_CYCLES` + 1.
- Press glitches shorter than `DEBOUNCE_CYCLES` cycles produce no event.
- Step period is exactly `TICK_DIV` cycles while RUNNING.
- After resume, the first step occurs `TICK_DIV` cycles after the edge on which `running` rises.
- `tick` is registered and is high for exactly 1 cycle per step.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- Macro: `COUNTER_SEQ_DEBOUNCE_EN`.
- **Defined:** the debounce counters are built as described above.
- **Undefined:**
  - The debounced level equals the synchronizer output, and `DEBOUNCE_CYCLES` is ignored.
  - Press-to-state latency is 3 edges (N + 3).
  - Every synchronized 1→0 transition is an event, including glitches.

## Test plan
All tests use `CLK_FREQ`=20, `TICK_HZ`=2 (so `TICK_DIV`=10) and `DEBOUNCE_CYCLES`=4, with `COUNTER_SEQ_DEBOUNCE_EN` defined unless stated.

1. **Reset release:** `count`=0, `running`=1, `dir_up`=1. Then `count`=1 after 10 cycles with one `tick` pulse, and after 160 cycles `count` has wrapped 15→0.
2. **Pause and resume:** hold `btn_pause_n` low for 10 cycles.
   - `running`→0 at edge N+7; `count` frozen, no `tick`.
   - A second press sets `running`→1, and the next step comes exactly 10 cycles later.
3. **Direction change at 0:** a direction press at `count`=0 gives `dir_up`=0 at N+7, and the next step gives `count`=15.
4. **Glitch and macro:**
   - Pulse `btn_dir_n` low for 3 cycles: no change to `dir_up`.
   - Rebuild without the macro: the same pulse toggles `dir_up` at N+3.
5. **Async reset mid-run:** drop `sys_rst_n` at `count`=9 between clock edges. All outputs reach their reset values before the next edge.
6. **Simultaneous events:** pause and direction events land on a step cycle. Expect `running`=0, `dir_up` toggled, `count` unchanged and no `tick`.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: prescaled 4-bit up/down counter with synchronized pause/direction buttons.
// Define COUNTER_SEQ_DEBOUNCE_EN to build the per-button debounce counters.
module counter_sequencer #(
  parameter int CLK_FREQ        = 27_000_000,
  parameter int TICK_HZ         = 2,
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       btn_pause_n,
  input  logic       btn_dir_n,
  output logic [3:0] count,
  output logic       running,
  output logic       dir_up,
  output logic       tick
);

  localparam int            TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : gTickDivCheck
    $error("counter_sequencer: CLK_FREQ/TICK_HZ must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : gDebounceCheck
    $error("counter_sequencer: DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [3:0]    count_q, count_d;
  logic          dirUp_q, dirUp_d;
  logic          tick_q;
  logic          step;

  // Bit 0 carries the pause button, bit 1 the direction button.
  logic [1:0] btnRaw, sync1_q, sync2_q, level, levelPrev_q, pressEvt_q;
  assign btnRaw = {btn_dir_n, btn_pause_n};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      levelPrev_q <= '1;
      pressEvt_q  <= '0;
    end else begin
      sync1_q     <= btnRaw;
      sync2_q     <= sync1_q;
      levelPrev_q <= level;
      pressEvt_q  <= levelPrev_q & ~level;
    end
  end

`ifdef COUNTER_SEQ_DEBOUNCE_EN
  localparam int            DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    level_q;
  logic [DW-1:0] dbCnt_q [2];

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level_q    <= '1;
      dbCnt_q[0] <= '0;
      dbCnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          dbCnt_q[i] <= '0;
        end else if (dbCnt_q[i] == DB_MAX) begin
          level_q[i] <= sync2_q[i];
          dbCnt_q[i] <= '0;
        end else begin
          dbCnt_q[i] <= dbCnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign level = level_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= RUNNING;
      prescaler_q <= '0;
      count_q     <= '0;
      dirUp_q     <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      count_q     <= count_d;
      dirUp_q     <= dirUp_d;
      tick_q      <= step;
    end
  end

  // A pause event pre-empts a step in the same cycle; a step always uses the old direction.
  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    count_d     = count_q;
    dirUp_d     = dirUp_q ^ pressEvt_q[1];
    step        = 1'b0;
    case (state_q)
      RUNNING: begin
        if (pressEvt_q[0]) begin
          state_d     = PAUSED;
          prescaler_d = '0;
        end else if (prescaler_q == PRE_MAX) begin
          prescaler_d = '0;
          step        = 1'b1;
          count_d     = dirUp_q ? (count_q + 4'd1) : (count_q - 4'd1);
        end else begin
          prescaler_d = prescaler_q + PW'(1);
        end
      end
      default: begin
        prescaler_d = '0;
        if (pressEvt_q[0]) begin
          state_d = RUNNING;
        end
      end
    endcase
  end

  assign count   = count_q;
  assign running = (state_q == RUNNING);
  assign dir_up  = dirUp_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with TICK_DIV = 10 and DEBOUNCE_CYCLES = 4.
// Expected latencies follow COUNTER_SEQ_DEBOUNCE_EN so the bench suits either build.
module tb_counter_sequencer;

  localparam int CLK_FREQ        = 20;
  localparam int TICK_HZ         = 2;
  localparam int DEBOUNCE_CYCLES = 4;

`ifdef COUNTER_SEQ_DEBOUNCE_EN
  localparam int   LAT            = 3 + DEBOUNCE_CYCLES;
  localparam logic GLITCH_TOGGLES = 1'b0;
`else
  localparam int   LAT            = 3;
  localparam logic GLITCH_TOGGLES = 1'b1;
`endif

  logic       sysClk;
  logic       rstN;
  logic       btnPauseN;
  logic       btnDirN;
  logic [3:0] count;
  logic       running;
  logic       dirUp;
  logic       tick;

  int   assertCount = 0;
  int   failCount   = 0;
  int   tickSeen;
  int   steps;
  logic expDir;

  counter_sequencer #(
    .CLK_FREQ        (CLK_FREQ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .sys_clk     (sysClk),
    .sys_rst_n   (rstN),
    .btn_pause_n (btnPauseN),
    .btn_dir_n   (btnDirN),
    .count       (count),
    .running     (running),
    .dir_up      (dirUp),
    .tick        (tick)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive the buttons, then advance nEdges clock edges, leaving time 1 unit past the last edge.
  task automatic applyStimulus(input logic pauseN, input logic dirN, input int nEdges);
    btnPauseN = pauseN;
    btnDirN   = dirN;
    repeat (nEdges) begin
      @(posedge sysClk);
      #1;
    end
  endtask

  initial begin
    rstN      = 1'b1;
    btnPauseN = 1'b1;
    btnDirN   = 1'b1;
    expDir    = 1'b1;

    $display("[TB] reset values");
    #1 rstN = 1'b0;
    #1;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_running", running, 1);
    checkOutput("rst_dir", dirUp, 1);
    checkOutput("rst_tick", tick, 0);
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("rst_hold_count", count, 0);
    rstN = 1'b1;

    $display("[TB] free run after reset release, 160 edges");
    for (int e = 1; e <= 160; e++) begin
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput($sformatf("run_count_e%0d", e), count, (e / 10) % 16);
      checkOutput($sformatf("run_tick_e%0d", e), tick, (e % 10 == 0) ? 1 : 0);
    end

    $display("[TB] direction press at count 0");
    applyStimulus(1'b1, 1'b0, LAT);
    checkOutput("dir_before_lat", dirUp, 1);
    applyStimulus(1'b1, 1'b0, 1);
    expDir = 1'b0;
    checkOutput("dir_at_lat", dirUp, expDir);
    checkOutput("dir_count_hold", count, 0);
    applyStimulus(1'b1, 1'b1, 8 - LAT);
    checkOutput("dir_prestep_count", count, 0);
    checkOutput("dir_prestep_tick", tick, 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("dir_step_wrap", count, 15);
    checkOutput("dir_step_tick", tick, 1);

    $display("[TB] pause for 10-cycle press");
    applyStimulus(1'b0, 1'b1, LAT);
    checkOutput("pause_before_lat", running, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("pause_at_lat", running, 0);
    checkOutput("pause_count", count, 15);
    applyStimulus(1'b0, 1'b1, 9 - LAT);
    tickSeen = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1);
      if (tick) tickSeen++;
    end
    checkOutput("paused_ticks", tickSeen, 0);
    checkOutput("paused_count", count, 15);
    checkOutput("paused_running", running, 0);

    $display("[TB] resume and first step");
    applyStimulus(1'b0, 1'b1, LAT);
    checkOutput("resume_before_lat", running, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("resume_at_lat", running, 1);
    applyStimulus(1'b0, 1'b1, 9 - LAT);
    applyStimulus(1'b1, 1'b1, LAT);
    checkOutput("resume_r9_count", count, 15);
    checkOutput("resume_r9_tick", tick, 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("resume_r10_count", count, 14);
    checkOutput("resume_r10_tick", tick, 1);

    $display("[TB] pause and direction events on a step cycle");
    applyStimulus(1'b1, 1'b1, 9 - LAT);
    applyStimulus(1'b0, 1'b0, LAT);
    checkOutput("simul_pre_running", running, 1);
    checkOutput("simul_pre_dir", dirUp, expDir);
    checkOutput("simul_pre_count", count, 14);
    applyStimulus(1'b0, 1'b0, 1);
    expDir = ~expDir;
    checkOutput("simul_running", running, 0);
    checkOutput("simul_dir", dirUp, expDir);
    checkOutput("simul_count", count, 14);
    checkOutput("simul_tick", tick, 0);
    tickSeen = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1);
      if (tick) tickSeen++;
    end
    checkOutput("simul_after_ticks", tickSeen, 0);
    checkOutput("simul_after_count", count, 14);

    $display("[TB] 3-cycle direction glitch");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, (k < 3) ? 1'b0 : 1'b1, 1);
      if (k == 2) checkOutput("glitch_n2_dir", dirUp, expDir);
      if (k == 3) checkOutput("glitch_n3_dir", dirUp, expDir ^ GLITCH_TOGGLES);
    end
    expDir = expDir ^ GLITCH_TOGGLES;
    checkOutput("glitch_final_dir", dirUp, expDir);

    $display("[TB] direction pulse of exactly DEBOUNCE_CYCLES");
    for (int k = 0; k <= LAT; k++) begin
      applyStimulus(1'b1, (k < DEBOUNCE_CYCLES) ? 1'b0 : 1'b1, 1);
      if (k == LAT - 1) checkOutput("pulse4_before_dir", dirUp, expDir);
    end
    expDir = ~expDir;
    checkOutput("pulse4_dir", dirUp, expDir);
    applyStimulus(1'b1, 1'b1, 8);
    checkOutput("pulse4_dir_settled", dirUp, expDir);

    $display("[TB] run to count 9, then async reset");
    applyStimulus(1'b0, 1'b1, LAT);
    checkOutput("resume2_before_lat", running, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("resume2_at_lat", running, 1);
    steps = expDir ? (9 - 14 + 16) : (14 - 9);
    applyStimulus(1'b1, 1'b1, 10 * steps);
    checkOutput("midrun_count", count, 9);
    checkOutput("midrun_tick", tick, 1);
    checkOutput("midrun_running", running, 1);
    #3 rstN = 1'b0;
    #1;
    checkOutput("async_rst_count", count, 0);
    checkOutput("async_rst_running", running, 1);
    checkOutput("async_rst_dir", dirUp, 1);
    checkOutput("async_rst_tick", tick, 0);
    @(posedge sysClk);
    #1;
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b1, 9);
    checkOutput("rerun_e9_count", count, 0);
    checkOutput("rerun_e9_tick", tick, 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("rerun_e10_count", count, 1);
    checkOutput("rerun_e10_tick", tick, 1);
    checkOutput("rerun_running", running, 1);
    checkOutput("rerun_dir", dirUp, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
